// File: rtl/button_shaper_pkg.sv
// Shared definitions for the button shaper array.
//   state_t / ST_*  : per-channel FSM state encoding
//   cnt_width()     : width of a saturating counter that must hold max_count
package button_shaper_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_DB_PRESS   = 3'd1;
    localparam state_t ST_PULSE      = 3'd2;
    localparam state_t ST_HELD       = 3'd3;
    localparam state_t ST_DB_RELEASE = 3'd4;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/button_shaper_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, press pulse and
// optional auto-repeat (macro BUTTON_SHAPER_REPEAT_EN).
// Ports:
//   Clock, Reset  rising-edge clock, synchronous active-low reset
//   button        raw active-low button (asynchronous)
//   enable        0 forces the FSM idle; synchronizer keeps sampling
//   b_out         registered single-cycle press (and repeat) pulse
//   held          registered level, 1 while the press is accepted
module button_shaper_channel
    import button_shaper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic Clock,
    input  logic Reset,
    input  logic button,
    input  logic enable,
    output logic b_out,
    output logic held
);

    localparam int              CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   DB_MAX = CW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("button_shaper_channel: DEBOUNCE_CYCLES out of range");
    end

    logic          sync1, sync2;
    state_t        state;
    logic [CW-1:0] cnt;

`ifdef BUTTON_SHAPER_REPEAT_EN
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = cnt_width(RMAX);
    localparam logic [RW-1:0] RPT_MAX = RW'(RMAX);

    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_shaper_channel: repeat timing out of range");
    end

    // rcnt counts cycles since the last pulse; the first interval uses the
    // delay, later ones the period. Fires when rcnt reaches interval-1
    // because the PULSE->HELD edge already counts as cycle 1.
    logic [RW-1:0] rcnt, rlim;
    logic          rpt_first;
    assign rlim = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`else
    // Repeat timing has no effect in this build; only reject nonsense values.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat
        $error("button_shaper_channel: negative repeat timing");
    end
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            state <= ST_IDLE;
            cnt   <= '0;
            b_out <= 1'b0;
            held  <= 1'b0;
`ifdef BUTTON_SHAPER_REPEAT_EN
            rcnt      <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            b_out <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                cnt   <= '0;
                held  <= 1'b0;
`ifdef BUTTON_SHAPER_REPEAT_EN
                rcnt      <= '0;
                rpt_first <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!sync2) begin
                            state <= ST_DB_PRESS;
                            cnt   <= CW'(1);
                        end
                    end
                    ST_DB_PRESS: begin
                        if (sync2) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_MAX) begin
                            // Pulse and held are registered on the same edge
                            // the FSM enters PULSE.
                            state <= ST_PULSE;
                            cnt   <= '0;
                            b_out <= 1'b1;
                            held  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_PULSE: begin
                        state <= ST_HELD;
`ifdef BUTTON_SHAPER_REPEAT_EN
                        rcnt      <= RW'(1);
                        rpt_first <= 1'b1;
`endif
                    end
                    ST_HELD: begin
                        if (sync2) begin
                            state <= ST_DB_RELEASE;
                            cnt   <= CW'(1);
                        end
`ifdef BUTTON_SHAPER_REPEAT_EN
                        else if (rcnt == rlim) begin
                            b_out     <= 1'b1;
                            rcnt      <= '0;
                            rpt_first <= 1'b0;
                        end else if (rcnt != RPT_MAX) begin
                            rcnt <= rcnt + RW'(1);
                        end
`endif
                    end
                    ST_DB_RELEASE: begin
                        // Repeat counter is left untouched here so it resumes
                        // on a bounce back to HELD.
                        if (!sync2) begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_MAX) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            held  <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_shaper_array.sv
// Array of independent debounced button channels.
// Optional auto-repeat: define BUTTON_SHAPER_REPEAT_EN.
// Ports:
//   Clock, Reset  rising-edge clock, synchronous active-low reset
//   Button        raw active-low buttons, one per channel
//   Enable        0 forces every channel idle
//   B_Out         registered one-cycle press pulses
//   Held          registered accepted-press levels
//   Any_Press     OR of B_Out
module button_shaper_array #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Button,
    input  logic              Enable,
    output logic [NUM_CH-1:0] B_Out,
    output logic [NUM_CH-1:0] Held,
    output logic              Any_Press
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        button_shaper_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .Clock (Clock),
            .Reset (Reset),
            .button(Button[i]),
            .enable(Enable),
            .b_out (B_Out[i]),
            .held  (Held[i])
        );
    end

    assign Any_Press = |B_Out;

endmodule
